mlp_layer_sequencer: RTL
========================

// Module: mlp_layer_sequencer
// PURPOSE
//  Control FSM that time-shares one MAC/bias/ReLU datapath across both dense layers of the MNIST MLP.
//  Layer 1 is IN_DIM->HID_DIM with ReLU; layer 2 is HID_DIM->OUT_DIM, linear.
//  Generates weight, activation and bias read addresses plus MAC/bias/write-back strobes.
//  Runs one inference per start; sits between the top-level host handshake and the datapath/memories.
// PARAMETERS
//  IN_DIM   784  layer-1 fan-in (input pixels)
//  HID_DIM  10   hidden neurons (layer-1 outputs, layer-2 fan-in)
//  OUT_DIM  10   output neurons
//  WA_W     13   weight address width; must hold IN_DIM*HID_DIM + HID_DIM*OUT_DIM - 1
//  AA_W     10   activation address width; must hold IN_DIM-1
// PORTS
//  clk      in   1     clock
//  rst      in   1     reset, asynchronous, active-high
//  start    in   1     one-cycle request for a new inference
//  abort    in   1     synchronous cancel of the current run
//  stall    in   1     memory not ready; freezes read issue
//  busy     out  1     high from the cycle after an accepted start until done/abort
//  done     out  1     sticky high after the final write-back; cleared by the next accepted start
//  w_addr   out  WA_W  weight ROM address
//  act_addr out  AA_W  activation read address
//  act_sel  out  1     0 = input buffer, 1 = hidden buffer
//  rd_en    out  1     weight and activation read strobe; read data is valid 1 cycle later
//  mac_clr  out  1     with mac_en: acc = product (load), not acc + product
//  mac_en   out  1     accumulate product of the returned read data
//  b_addr   out  5     bias address: L1 = neuron, L2 = HID_DIM + neuron
//  bias_en  out  1     acc += bias[b_addr]
//  wb_en    out  1     write saturated/truncated acc to the destination
//  wb_addr  out  4     destination neuron index
//  wb_sel   out  1     0 = hidden buffer, 1 = output register file
//  relu_en  out  1     apply ReLU on write-back; high only in L1
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0.
//  FSM states: IDLE, L1, L2, FIN. Each neuron has phases ISSUE -> DRAIN -> BIAS -> WB.
//   IDLE: start -> L1, neuron=0, k=0; done<=0; busy<=1.
//   L1 -> L2 after neuron HID_DIM-1 completes WB. L2 -> FIN after neuron OUT_DIM-1 completes WB.
//   FIN: 1 cycle; done<=1, busy<=0, then IDLE.
//  Per neuron with fan-in N, cycle 0 = first issue:
//   ISSUE (cycles 0..N-1): rd_en=1, k increments.
//    L1: w_addr = neuron*IN_DIM + k, act_sel=0.
//    L2: w_addr = IN_DIM*HID_DIM + neuron*HID_DIM + k, act_sel=1.
//    act_addr = k in both layers.
//   mac_en = rd_en delayed 1 cycle (registered). mac_clr=1 on the k=0 beat only.
//   DRAIN (cycle N): waits until the last mac_en is out of the pipe.
//   BIAS (cycle N+1): bias_en=1.
//   WB (cycle N+2): wb_en=1, wb_addr=neuron, wb_sel=(layer==2), relu_en=(layer==1).
//   Next neuron issue starts at cycle N+3. Neuron cost is N+3 cycles with no stall.
//  Full-run latency: start sampled at T -> done high at T+1+HID_DIM*(IN_DIM+3)+OUT_DIM*(HID_DIM+3).
//   Defaults give T+8001.
//  stall: during ISSUE, rd_en=0 and k/neuron hold. An already-issued read still yields its mac_en.
//   DRAIN/BIAS/WB ignore stall. Each stalled cycle adds exactly 1 cycle of latency.
//  start while busy: ignored. start in IDLE with done=1: accepted, done clears.
//  abort (any non-IDLE state): next cycle IDLE, all strobes 0, busy=0, done stays 0.
//   The in-flight mac_en is suppressed. abort outranks stall; abort and start together in IDLE: start ignored.
//  rst mid-run: immediate return to reset values; no partial wb_en.
//  Strobes rd_en, mac_en, bias_en and wb_en are mutually exclusive except rd_en with mac_en during ISSUE.
// STRUCTURE
//  mlp_pkg: IN_DIM/HID_DIM/OUT_DIM, W2_BASE = IN_DIM*HID_DIM, B2_BASE = HID_DIM, and the state/phase enum.
//  Sub-module mlp_addr_gen: nested k/neuron counters with terminal flags and the w_addr base multiply-add.
//   Counters hold on stall.
//  The top holds the FSM, the rd_en->mac_en pipeline register and the strobe decode.
// TESTING
//  1 Reset: rst mid-L1 (neuron 4, k=300) -> all outputs 0 same cycle; no wb_en after release.
//  2 Full run: start at T -> first rd_en at T+1 with w_addr=0, act_addr=0.
//    Expect 10 L1 wb_en (relu_en=1, wb_sel=0), then 10 L2 wb_en (relu_en=0, wb_sel=1); done at T+8001.
//  3 Addressing: L2 neuron 3, k=5 -> w_addr=7875, act_addr=5, act_sel=1; its bias beat has b_addr=13.
//  4 Stall: stall high 4 cycles in L1 ISSUE -> done at T+8005; exactly 784 mac_en for that neuron, first with mac_clr.
//  5 Handshake: start while busy -> no effect; start after done -> done=0 next cycle, new run identical to test 2.
//  6 Abort: abort during L2 neuron 2 ISSUE -> next cycle busy=0, done=0, no further mac_en/wb_en.

Source files
------------

// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared constants and state types for the MNIST MLP layer sequencer.
//   IN_DIM / HID_DIM / OUT_DIM : layer geometry (784 -> 10 -> 10)
//   WA_W / AA_W                : weight and activation address widths
//   W2_BASE                    : first layer-2 word in the weight ROM
//   B2_BASE                    : first layer-2 entry in the bias table
//   state_e / phase_e          : top-level run state and per-neuron phase
// -----------------------------------------------------------------------------
package mlp_pkg;

  localparam int IN_DIM  = 784;
  localparam int HID_DIM = 10;
  localparam int OUT_DIM = 10;
  localparam int WA_W    = 13;
  localparam int AA_W    = 10;

  localparam int W2_BASE = IN_DIM * HID_DIM;
  localparam int B2_BASE = HID_DIM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    P_ISSUE,
    P_DRAIN,
    P_BIAS,
    P_WB
  } phase_e;

endpackage

// File: rtl/mlp_addr_gen.sv
// -----------------------------------------------------------------------------
// mlp_addr_gen
// Nested fan-in (k) / neuron counters plus the weight ROM address for the
// current beat. Counters only move when told to, so a stalled issue cycle
// simply holds them.
//   clk, rst        : clock, asynchronous active-high reset
//   clear_i         : synchronous return of both counters to 0
//   issue_i         : one read issued this cycle; advance k
//   advance_i       : neuron write-back this cycle; advance neuron
//   l2_i            : 1 while running layer 2 (selects fan-in and ROM region)
//   k_o, neuron_o   : current counter values
//   k_last_o        : k is the last fan-in index for this layer
//   neuron_last_o   : neuron is the last neuron of this layer
//   w_addr_o        : weight ROM address for (layer, neuron, k)
// -----------------------------------------------------------------------------
module mlp_addr_gen
  import mlp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            issue_i,
  input  logic            advance_i,
  input  logic            l2_i,
  output logic [AA_W-1:0] k_o,
  output logic [3:0]      neuron_o,
  output logic            k_last_o,
  output logic            neuron_last_o,
  output logic [WA_W-1:0] w_addr_o
);

  logic [AA_W-1:0] k_q;
  logic [3:0]      neuron_q;
  logic [AA_W-1:0] kMax;
  logic [3:0]      neuronMax;
  logic [WA_W-1:0] nExt;
  logic [WA_W-1:0] kExt;

  always_comb begin
    kMax      = l2_i ? AA_W'(HID_DIM - 1) : AA_W'(IN_DIM - 1);
    neuronMax = l2_i ? 4'(OUT_DIM - 1) : 4'(HID_DIM - 1);
  end

  assign k_last_o      = (k_q == kMax);
  assign neuron_last_o = (neuron_q == neuronMax);

  // Layer 2 weights are packed directly after all of layer 1, each neuron
  // owning a contiguous run of fan-in words.
  always_comb begin
    nExt = WA_W'(neuron_q);
    kExt = WA_W'(k_q);
    if (l2_i)
      w_addr_o = WA_W'(W2_BASE) + nExt * WA_W'(HID_DIM) + kExt;
    else
      w_addr_o = nExt * WA_W'(IN_DIM) + kExt;
  end

  // k wraps on the last issue so the next neuron starts at 0; neuron wraps
  // on the last write-back of a layer so layer 2 starts at neuron 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      neuron_q <= '0;
    end else if (clear_i) begin
      k_q      <= '0;
      neuron_q <= '0;
    end else begin
      if (issue_i)
        k_q <= k_last_o ? '0 : k_q + AA_W'(1);
      if (advance_i)
        neuron_q <= neuron_last_o ? '0 : neuron_q + 4'd1;
    end
  end

  assign k_o      = k_q;
  assign neuron_o = neuron_q;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
// Control FSM that time-shares one MAC/bias/ReLU datapath across both dense
// layers of the MNIST MLP (784->10 with ReLU, then 10->10 linear). Each
// neuron runs ISSUE (fan-in reads) -> DRAIN -> BIAS -> WB.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle request for a new inference (ignored while busy)
//   abort     : cancel the current run, back to IDLE next cycle
//   stall     : memory not ready; holds read issue
//   busy      : run in progress
//   done      : sticky completion flag, cleared by the next accepted start
//   w_addr    : weight ROM address
//   act_addr  : activation read address (= k)
//   act_sel   : 0 input buffer, 1 hidden buffer
//   rd_en     : weight/activation read strobe (data valid next cycle)
//   mac_clr   : with mac_en, load instead of accumulate
//   mac_en    : accumulate the product of the returned read data
//   b_addr    : bias table address
//   bias_en   : add bias[b_addr] to the accumulator
//   wb_en     : write accumulator to destination
//   wb_addr   : destination neuron
//   wb_sel    : 0 hidden buffer, 1 output register file
//   relu_en   : apply ReLU on write-back (layer 1)
// -----------------------------------------------------------------------------
module mlp_layer_sequencer
  import mlp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic [WA_W-1:0] w_addr,
  output logic [AA_W-1:0] act_addr,
  output logic            act_sel,
  output logic            rd_en,
  output logic            mac_clr,
  output logic            mac_en,
  output logic [4:0]      b_addr,
  output logic            bias_en,
  output logic            wb_en,
  output logic [3:0]      wb_addr,
  output logic            wb_sel,
  output logic            relu_en
);

  state_e          state_q;
  phase_e          phase_q;
  logic            busy_q;
  logic            done_q;
  logic            macEn_q;
  logic            macClr_q;

  logic            inRun;
  logic            inL2;
  logic            readIssue;
  logic            accepted;
  logic            counterClear;
  logic            neuronAdvance;
  logic [AA_W-1:0] kCur;
  logic [3:0]      neuronCur;
  logic            kLast;
  logic            neuronLast;
  logic [WA_W-1:0] wAddrCur;

  assign inRun = (state_q == S_L1) || (state_q == S_L2);
  assign inL2  = (state_q == S_L2);

  // A read goes out on every unstalled ISSUE cycle; stall only blocks new
  // issue, never the later phases.
  assign readIssue     = inRun && (phase_q == P_ISSUE) && !stall;
  assign accepted      = (state_q == S_IDLE) && start && !abort;
  assign counterClear  = accepted || ((state_q != S_IDLE) && abort);
  assign neuronAdvance = inRun && (phase_q == P_WB) && !abort;

  mlp_addr_gen u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (counterClear),
    .issue_i       (readIssue),
    .advance_i     (neuronAdvance),
    .l2_i          (inL2),
    .k_o           (kCur),
    .neuron_o      (neuronCur),
    .k_last_o      (kLast),
    .neuron_last_o (neuronLast),
    .w_addr_o      (wAddrCur)
  );

  // Run FSM plus the one-deep rd_en -> mac_en pipe. Abort kills the read
  // issued in the abort cycle so no mac_en escapes after returning to IDLE.
  // The last write-back of layer 2 lands in FIN with done already set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= P_ISSUE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      macEn_q  <= 1'b0;
      macClr_q <= 1'b0;
    end else begin
      macEn_q  <= readIssue && !abort;
      macClr_q <= readIssue && !abort && (kCur == '0);
      case (state_q)
        S_IDLE: begin
          if (accepted) begin
            state_q <= S_L1;
            phase_q <= P_ISSUE;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_L1, S_L2: begin
          if (abort) begin
            state_q <= S_IDLE;
            phase_q <= P_ISSUE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            case (phase_q)
              P_ISSUE: if (readIssue && kLast) phase_q <= P_DRAIN;
              P_DRAIN: phase_q <= P_BIAS;
              P_BIAS:  phase_q <= P_WB;
              P_WB: begin
                phase_q <= P_ISSUE;
                if (neuronLast) begin
                  if (state_q == S_L1) begin
                    state_q <= S_L2;
                  end else begin
                    state_q <= S_FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                  end
                end
              end
              default: phase_q <= P_ISSUE;
            endcase
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          phase_q <= P_ISSUE;
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= P_ISSUE;
        end
      endcase
    end
  end

  // Strobe decode. Everything is derived from registered state, so reset
  // drives every output to 0 immediately (counters and neuron are 0 too).
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = readIssue;
  assign mac_en   = macEn_q;
  assign mac_clr  = macClr_q;
  assign bias_en  = inRun && (phase_q == P_BIAS);
  assign wb_en    = inRun && (phase_q == P_WB);
  assign w_addr   = wAddrCur;
  assign act_addr = kCur;
  assign act_sel  = inL2;
  assign b_addr   = inL2 ? 5'(B2_BASE) + {1'b0, neuronCur} : {1'b0, neuronCur};
  assign wb_addr  = neuronCur;
  assign wb_sel   = inL2;
  assign relu_en  = (state_q == S_L1);

endmodule
